// File: rtl/mc_control_unit.sv
// -----------------------------------------------------------------------------
// mc_control_unit
// Multi-cycle control FSM for the 16-bit CPU. It takes the latched instruction
// register and drives every datapath control strobe. It sequences
// IF/ID/EX/MEM/WB for each instruction, waits on memory, counts retired
// instructions, and flags WWD output and HLT.
//
// Ports
//   clk          clock; all state updates happen on the rising edge
//   reset_n      synchronous reset, active HIGH (1 = reset)
//   inst         instruction register: [15:12] opcode, [5:0] func
//   mem_ready    memory finished the current read/write this cycle
//   PCWriteCond  PC write if ALU zero     PCWrite    unconditional PC write
//   IorD         mem addr 0:PC 1:ALUOut    MemRead    memory read request
//   MemWrite     memory write request      MemtoReg   RF data from MDR
//   IRWrite      latch fetched instruction
//   PCSource     0 ALU, 1 ALUOut, 2 jump target, 3 RF read port 1
//   ALUOp/func   ALU operation / R-type function
//   ALUSrcB      0 RF2, 1 const 1, 2 sign-ext imm   ALUSrcA  0 PC, 1 RF1
//   RegWrite     RF write enable
//   RegDst       0 inst[9:8], 1 inst[7:6], 2 reg 2
//   num_inst     retired-instruction count (wraps)
//   wwd_valid    one-cycle pulse: datapath output_port valid
//   is_halted    HLT executed
// -----------------------------------------------------------------------------
module mc_control_unit #(
    parameter int         WORD_SIZE = 16,
    parameter logic [3:0] ADD_ALUOP = 4'd4
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [WORD_SIZE-1:0] inst,
    input  logic                 mem_ready,
    output logic                 PCWriteCond,
    output logic                 PCWrite,
    output logic                 IorD,
    output logic                 MemRead,
    output logic                 MemWrite,
    output logic                 MemtoReg,
    output logic                 IRWrite,
    output logic [1:0]           PCSource,
    output logic [3:0]           ALUOp,
    output logic [5:0]           func,
    output logic [1:0]           ALUSrcB,
    output logic                 ALUSrcA,
    output logic                 RegWrite,
    output logic [1:0]           RegDst,
    output logic [WORD_SIZE-1:0] num_inst,
    output logic                 wwd_valid,
    output logic                 is_halted
);

    typedef enum logic [2:0] {
        S_IF   = 3'd0,
        S_ID   = 3'd1,
        S_EX   = 3'd2,
        S_MEM  = 3'd3,
        S_WB   = 3'd4,
        S_HALT = 3'd5
    } state_t;

    localparam logic [3:0] OP_LWD   = 4'd7;
    localparam logic [3:0] OP_SWD   = 4'd8;
    localparam logic [3:0] OP_JMP   = 4'd9;
    localparam logic [3:0] OP_RTYPE = 4'd15;
    localparam logic [5:0] FN_JPR   = 6'd25;
    localparam logic [5:0] FN_WWD   = 6'd28;
    localparam logic [5:0] FN_HLT   = 6'd29;
    localparam logic [5:0] FN_ALU_MAX = 6'd7;   // R-type ALU functions are 0..7

    state_t                 r_state;
    state_t                 w_next;
    logic [WORD_SIZE-1:0]   r_num_inst;
    logic                   r_is_halted;
    logic                   w_retire;

    logic [3:0] w_opcode;
    logic [5:0] w_func;
    logic       w_is_rtype, w_is_rtype_alu, w_is_branch, w_is_imm;
    logic       w_is_lwd, w_is_swd, w_is_jmp, w_is_jpr, w_is_wwd, w_is_hlt;
    logic       w_unused_inst;

    assign w_opcode       = inst[15:12];
    assign w_func         = inst[5:0];
    assign w_unused_inst  = ^inst[11:6];   // register fields belong to the datapath
    assign w_is_rtype     = (w_opcode == OP_RTYPE);
    assign w_is_rtype_alu = w_is_rtype && (w_func <= FN_ALU_MAX);
    assign w_is_branch    = (w_opcode <= 4'd3);
    assign w_is_imm       = (w_opcode >= 4'd4) && (w_opcode <= 4'd6);
    assign w_is_lwd       = (w_opcode == OP_LWD);
    assign w_is_swd       = (w_opcode == OP_SWD);
    assign w_is_jmp       = (w_opcode == OP_JMP);
    assign w_is_jpr       = w_is_rtype && (w_func == FN_JPR);
    assign w_is_wwd       = w_is_rtype && (w_func == FN_WWD);
    assign w_is_hlt       = w_is_rtype && (w_func == FN_HLT);

    // NOTE: every output and w_next gets a default before the case so no
    // path through this block can leave a signal unassigned and infer a latch.
    always_comb begin
        PCWriteCond = 1'b0;
        PCWrite     = 1'b0;
        IorD        = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        MemtoReg    = 1'b0;
        IRWrite     = 1'b0;
        PCSource    = 2'd0;
        ALUOp       = 4'd0;
        func        = 6'd0;
        ALUSrcB     = 2'd0;
        ALUSrcA     = 1'b0;
        RegWrite    = 1'b0;
        RegDst      = 2'd0;
        wwd_valid   = 1'b0;
        w_retire    = 1'b0;
        w_next      = r_state;

        // Strobes are suppressed for the whole reset cycle so an abandoned
        // instruction cannot disturb the datapath.
        if (!reset_n) begin
            case (r_state)
                S_IF: begin
                    MemRead = 1'b1;
                    ALUSrcB = 2'd1;
                    ALUOp   = ADD_ALUOP;
                    IRWrite = mem_ready;
                    PCWrite = mem_ready;
                    if (mem_ready) w_next = S_ID;
                end
                S_ID: begin
                    // ALUOut <= PC+1+imm: branch target ready for EX.
                    ALUSrcB = 2'd2;
                    ALUOp   = ADD_ALUOP;
                    if (w_is_jmp) begin
                        PCWrite  = 1'b1;
                        PCSource = 2'd2;
                        w_next   = S_IF;
                    end else if (w_is_jpr) begin
                        PCWrite  = 1'b1;
                        PCSource = 2'd3;
                        w_next   = S_IF;
                    end else if (w_is_wwd) begin
                        ALUOp     = 4'd15;
                        func      = FN_WWD;
                        wwd_valid = 1'b1;
                        w_next    = S_IF;
                    end else if (w_is_hlt) begin
                        w_next = S_HALT;
                    end else if (w_is_rtype_alu || w_is_imm || w_is_lwd ||
                                 w_is_swd || w_is_branch) begin
                        w_next = S_EX;
                    end else begin
                        w_next = S_IF;   // unsupported: retired as a NOP
                    end
                    w_retire = (w_next != S_EX);
                end
                S_EX: begin
                    ALUSrcA = 1'b1;
                    if (w_is_rtype) begin
                        ALUOp  = 4'd15;
                        func   = w_func;
                        w_next = S_WB;
                    end else if (w_is_imm) begin
                        ALUSrcB = 2'd2;
                        ALUOp   = w_opcode;
                        w_next  = S_WB;
                    end else if (w_is_lwd || w_is_swd) begin
                        ALUSrcB = 2'd2;
                        ALUOp   = ADD_ALUOP;
                        w_next  = S_MEM;
                    end else begin
                        // Branch: ALU compares, zero=1 loads the target from ALUOut.
                        ALUOp       = w_opcode;
                        PCWriteCond = 1'b1;
                        PCSource    = 2'd1;
                        w_next      = S_IF;
                        w_retire    = 1'b1;
                    end
                end
                S_MEM: begin
                    IorD     = 1'b1;
                    MemRead  = w_is_lwd;
                    MemWrite = w_is_swd;
                    if (mem_ready) begin
                        w_next   = w_is_lwd ? S_WB : S_IF;
                        w_retire = !w_is_lwd;
                    end
                end
                S_WB: begin
                    RegWrite = 1'b1;
                    MemtoReg = w_is_lwd;
                    RegDst   = w_is_rtype ? 2'd1 : 2'd0;
                    w_next   = S_IF;
                    w_retire = 1'b1;
                end
                S_HALT: w_next = S_HALT;
                default: w_next = S_IF;
            endcase
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (reset_n) begin
            r_state     <= S_IF;
            r_num_inst  <= '0;
            r_is_halted <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_retire) r_num_inst <= r_num_inst + 1'b1;
            if (w_next == S_HALT) r_is_halted <= 1'b1;
        end
    end

    assign num_inst  = r_num_inst;
    assign is_halted = r_is_halted;

endmodule

// File: tb/tb_mc_control_unit.sv
// -----------------------------------------------------------------------------
// tb_mc_control_unit
// Directed bench for mc_control_unit. Each step drives inst/mem_ready/reset_n,
// pushes the expected control word to a scoreboard queue, and on the falling
// edge pops it and compares against the DUT outputs.
// -----------------------------------------------------------------------------
module tb_mc_control_unit;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [15:0] inst;
    logic        mem_ready;
    logic        PCWriteCond, PCWrite, IorD, MemRead, MemWrite, MemtoReg, IRWrite;
    logic [1:0]  PCSource;
    logic [3:0]  ALUOp;
    logic [5:0]  func;
    logic [1:0]  ALUSrcB;
    logic        ALUSrcA, RegWrite;
    logic [1:0]  RegDst;
    logic [15:0] num_inst;
    logic        wwd_valid, is_halted;

    always #5 clk = ~clk;

    mc_control_unit dut (
        .clk(clk), .reset_n(reset_n), .inst(inst), .mem_ready(mem_ready),
        .PCWriteCond(PCWriteCond), .PCWrite(PCWrite), .IorD(IorD),
        .MemRead(MemRead), .MemWrite(MemWrite), .MemtoReg(MemtoReg),
        .IRWrite(IRWrite), .PCSource(PCSource), .ALUOp(ALUOp), .func(func),
        .ALUSrcB(ALUSrcB), .ALUSrcA(ALUSrcA), .RegWrite(RegWrite),
        .RegDst(RegDst), .num_inst(num_inst), .wwd_valid(wwd_valid),
        .is_halted(is_halted)
    );

    typedef struct packed {
        logic        pcwc, pcw, iord, mrd, mwr, m2r, irw;
        logic [1:0]  pcsrc;
        logic [3:0]  aluop;
        logic [5:0]  fn;
        logic [1:0]  srcb;
        logic        srca, regw;
        logic [1:0]  regdst;
        logic        wwd, halted;
        logic [15:0] num;
    } ctl_t;

    ctl_t sb_q[$];
    int   checks = 0;
    int   errors = 0;

    function automatic ctl_t base(input logic [15:0] n);
        ctl_t e;
        e = '0;
        e.num = n;
        return e;
    endfunction

    // Fetch cycle: read PC, PC+1 in ALU, IR/PC written only once memory answers.
    function automatic ctl_t f_if(input logic [15:0] n, input logic rdy);
        ctl_t e;
        e = base(n);
        e.mrd = 1'b1; e.srcb = 2'd1; e.aluop = 4'd4;
        e.irw = rdy;  e.pcw = rdy;
        return e;
    endfunction

    // Decode cycle: branch target PC+1+imm.
    function automatic ctl_t f_id(input logic [15:0] n);
        ctl_t e;
        e = base(n);
        e.srcb = 2'd2; e.aluop = 4'd4;
        return e;
    endfunction

    task automatic step(input string tag, input logic [15:0] i_inst,
                        input logic rdy, input logic rst, input ctl_t e);
        ctl_t obs, exp_v;
        inst      = i_inst;
        mem_ready = rdy;
        reset_n   = rst;
        sb_q.push_back(e);
        @(negedge clk);
        obs.pcwc = PCWriteCond; obs.pcw = PCWrite; obs.iord = IorD;
        obs.mrd = MemRead; obs.mwr = MemWrite; obs.m2r = MemtoReg;
        obs.irw = IRWrite; obs.pcsrc = PCSource; obs.aluop = ALUOp;
        obs.fn = func; obs.srcb = ALUSrcB; obs.srca = ALUSrcA;
        obs.regw = RegWrite; obs.regdst = RegDst; obs.wwd = wwd_valid;
        obs.halted = is_halted; obs.num = num_inst;
        exp_v = sb_q.pop_front();
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        ctl_t e;
        reset_n   = 1'b1;
        inst      = 16'h0000;
        mem_ready = 1'b0;
        @(posedge clk);
        #1;
        step("reset", 16'h0000, 1'b1, 1'b1, base(16'd0));

        // ADD R1,R2->R3: IF, ID, EX, WB
        step("add_if", 16'hF6C0, 1'b1, 1'b0, f_if(16'd0, 1'b1));
        step("add_id", 16'hF6C0, 1'b1, 1'b0, f_id(16'd0));
        e = base(16'd0); e.srca = 1'b1; e.aluop = 4'd15; e.fn = 6'd0;
        step("add_ex", 16'hF6C0, 1'b1, 1'b0, e);
        e = base(16'd0); e.regw = 1'b1; e.regdst = 2'd1;
        step("add_wb", 16'hF6C0, 1'b1, 1'b0, e);

        // LWD with memory stalling two cycles in MEM: 7 cycles total
        step("lwd_if", 16'h7500, 1'b1, 1'b0, f_if(16'd1, 1'b1));
        step("lwd_id", 16'h7500, 1'b1, 1'b0, f_id(16'd1));
        e = base(16'd1); e.srca = 1'b1; e.srcb = 2'd2; e.aluop = 4'd4;
        step("lwd_ex", 16'h7500, 1'b1, 1'b0, e);
        e = base(16'd1); e.iord = 1'b1; e.mrd = 1'b1;
        step("lwd_mem0", 16'h7500, 1'b0, 1'b0, e);
        step("lwd_mem1", 16'h7500, 1'b0, 1'b0, e);
        step("lwd_mem2", 16'h7500, 1'b1, 1'b0, e);
        e = base(16'd1); e.regw = 1'b1; e.m2r = 1'b1;
        step("lwd_wb", 16'h7500, 1'b1, 1'b0, e);

        // BEQ, with one fetch stall first
        step("beq_if_wait", 16'h1403, 1'b0, 1'b0, f_if(16'd2, 1'b0));
        step("beq_if", 16'h1403, 1'b1, 1'b0, f_if(16'd2, 1'b1));
        step("beq_id", 16'h1403, 1'b1, 1'b0, f_id(16'd2));
        e = base(16'd2); e.srca = 1'b1; e.aluop = 4'd1; e.pcwc = 1'b1; e.pcsrc = 2'd1;
        step("beq_ex", 16'h1403, 1'b1, 1'b0, e);

        // WWD: pulse in ID only
        step("wwd_if", 16'hF01C, 1'b1, 1'b0, f_if(16'd3, 1'b1));
        e = f_id(16'd3); e.aluop = 4'd15; e.fn = 6'd28; e.wwd = 1'b1;
        step("wwd_id", 16'hF01C, 1'b1, 1'b0, e);

        // JMP and JPR
        step("jmp_if", 16'h9000, 1'b1, 1'b0, f_if(16'd4, 1'b1));
        e = f_id(16'd4); e.pcw = 1'b1; e.pcsrc = 2'd2;
        step("jmp_id", 16'h9000, 1'b1, 1'b0, e);
        step("jpr_if", 16'hF019, 1'b1, 1'b0, f_if(16'd5, 1'b1));
        e = f_id(16'd5); e.pcw = 1'b1; e.pcsrc = 2'd3;
        step("jpr_id", 16'hF019, 1'b1, 1'b0, e);

        // Unsupported opcode retires as NOP after ID
        step("nop_if", 16'hA000, 1'b1, 1'b0, f_if(16'd6, 1'b1));
        step("nop_id", 16'hA000, 1'b1, 1'b0, f_id(16'd6));

        // SWD aborted by reset in MEM
        step("swd_if", 16'h8500, 1'b1, 1'b0, f_if(16'd7, 1'b1));
        step("swd_id", 16'h8500, 1'b1, 1'b0, f_id(16'd7));
        e = base(16'd7); e.srca = 1'b1; e.srcb = 2'd2; e.aluop = 4'd4;
        step("swd_ex", 16'h8500, 1'b1, 1'b0, e);
        e = base(16'd7); e.iord = 1'b1; e.mwr = 1'b1;
        step("swd_mem", 16'h8500, 1'b0, 1'b0, e);
        step("swd_reset", 16'h8500, 1'b0, 1'b1, base(16'd7));
        step("after_reset_if", 16'h8500, 1'b0, 1'b0, f_if(16'd0, 1'b0));

        // HLT: halts after ID and stays put for 100 cycles
        step("hlt_if", 16'hF01D, 1'b1, 1'b0, f_if(16'd0, 1'b1));
        step("hlt_id", 16'hF01D, 1'b1, 1'b0, f_id(16'd0));
        e = base(16'd1); e.halted = 1'b1;
        for (int i = 0; i < 100; i++) begin
            step("halt_hold", 16'($urandom), 1'b1, 1'b0, e);
        end
        step("halt_reset", 16'h0000, 1'b1, 1'b1, e);
        step("halt_cleared", 16'h0000, 1'b0, 1'b0, f_if(16'd0, 1'b0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
